// File: rtl/cache_request_sequencer_pkg.sv
// Shared types for the cache request sequencer: widths, FSM states and the queued request.
package cache_request_sequencer_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wr;
   } req_t;

endpackage

// File: rtl/cache_request_sequencer_fifo.sv
// Request queue between the processor-side handshake and the sequencer FSM.
module seq_req_fifo
   import cache_request_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  req_t                   push_req,
   input  logic                   pop,
   output req_t                   head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   req_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // full/empty come from the registered count only, so a same-cycle pop never frees a slot
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_req;
   end

endmodule

// File: rtl/cache_request_sequencer.sv
// Front-end that queues processor requests and issues them one at a time to the cache.
//   state | meaning
//   IDLE  | waiting for a queued request; pops the head when one is present
//   ISSUE | cache_start pulse, timeout counter cleared
//   WAIT  | address/wrEn held, waiting for cache_done or timeout
//   RESP  | response presented until rsp_ready
module cache_request_sequencer
   import cache_request_sequencer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              globalclock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_wr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_wr,
   output logic              rsp_err,
   output logic              cache_start,
   output logic [ADDR_W-1:0] cache_address,
   output logic              cache_wrEn,
   input  logic              cache_done,
   input  logic [DATA_W-1:0] cache_data,
   output logic              busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   state_t                 state;
   logic [CNT_W-1:0]       wait_cnt;
   req_t                   head;
   req_t                   new_req;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic [$clog2(DEPTH):0] count;

   assign new_req   = '{addr: req_addr, wr: req_wr};
   assign req_ready = !full;
   assign pop       = (state == IDLE) && !empty;
   assign busy      = (state != IDLE) || (count != '0);

   seq_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (globalclock),
      .rst      (reset),
      .push     (req_valid && req_ready),
      .push_req (new_req),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge globalclock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         cache_start   <= 1'b0;
         cache_address <= '0;
         cache_wrEn    <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_wr        <= 1'b0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  cache_address <= head.addr;
                  cache_wrEn    <= head.wr;
                  cache_start   <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               cache_start <= 1'b0;
               wait_cnt    <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               // done takes priority over a timeout landing in the same cycle
               if (cache_done) begin
                  rsp_data  <= cache_wrEn ? '0 : cache_data;
                  rsp_wr    <= cache_wrEn;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (wait_cnt == LAST_WAIT) begin
                  wait_cnt  <= wait_cnt + 1'b1;
                  rsp_data  <= '0;
                  rsp_wr    <= cache_wrEn;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_request_sequencer.sv
// Directed bench for cache_request_sequencer with a hand-driven cache model (TIMEOUT = 8).
module tb_cache_request_sequencer;
   import cache_request_sequencer_pkg::*;

   logic              globalclock = 1'b0;
   logic              reset       = 1'b1;
   logic              req_valid   = 1'b0;
   logic [ADDR_W-1:0] req_addr    = '0;
   logic              req_wr      = 1'b0;
   logic              rsp_ready   = 1'b0;
   logic              cache_done  = 1'b0;
   logic [DATA_W-1:0] cache_data  = '0;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_wr;
   logic              rsp_err;
   logic              cache_start;
   logic [ADDR_W-1:0] cache_address;
   logic              cache_wrEn;
   logic              busy;

   int total      = 0;
   int bad        = 0;
   int start_cnt  = 0;
   int accept_cnt = 0;

   cache_request_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
      .globalclock   (globalclock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_wr        (req_wr),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_wr        (rsp_wr),
      .rsp_err       (rsp_err),
      .cache_start   (cache_start),
      .cache_address (cache_address),
      .cache_wrEn    (cache_wrEn),
      .cache_done    (cache_done),
      .cache_data    (cache_data),
      .busy          (busy)
   );

   always #5 globalclock = ~globalclock;

   always @(posedge globalclock) begin
      if (cache_start === 1'b1) start_cnt <= start_cnt + 1;
      if (req_valid && req_ready === 1'b1) accept_cnt <= accept_cnt + 1;
   end

   task automatic tick();
      @(posedge globalclock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [ADDR_W-1:0] addr, input logic wr);
      req_valid = 1'b1;
      req_addr  = addr;
      req_wr    = wr;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20 && cache_start !== 1'b1; i++) tick();
      check("start_seen", 32'(cache_start), 32'd1);
   endtask

   // one full transaction: start, held address during WAIT, done after 'delay' cycles, handshake
   task automatic serve(input logic [ADDR_W-1:0] addr, input logic wr, input int delay,
                        input logic [DATA_W-1:0] data);
      wait_start();
      check("issue_addr", 32'(cache_address), 32'(addr));
      check("issue_wr", 32'(cache_wrEn), 32'(wr));
      for (int i = 1; i < delay; i++) begin
         tick();
         check("wait_start_low", 32'(cache_start), 32'd0);
         check("wait_addr_hold", 32'(cache_address), 32'(addr));
         check("wait_wr_hold", 32'(cache_wrEn), 32'(wr));
         check("wait_no_rsp", 32'(rsp_valid), 32'd0);
      end
      cache_data = data;
      cache_done = 1'b1;
      tick();
      cache_done = 1'b0;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", rsp_data, wr ? 32'd0 : data);
      check("rsp_wr", 32'(rsp_wr), 32'(wr));
      check("rsp_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int s0;
      int a0;
      int n;
      logic seen_rsp;
      logic seen_start;

      // reset state
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_start", 32'(cache_start), 32'd0);
      check("rst_addr", 32'(cache_address), 32'd0);
      reset = 1'b0;
      tick();

      // single read, with accept-to-start latency
      s0 = start_cnt;
      push_one(15'h0123, 1'b0);
      check("lat_start_early", 32'(cache_start), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
      tick();
      check("lat_start", 32'(cache_start), 32'd1);
      serve(15'h0123, 1'b0, 5, 32'hDEADBEEF);
      check("read_one_start", 32'(start_cnt - s0), 32'd1);
      check("read_idle", 32'(busy), 32'd0);

      // write
      push_one(15'h7FFF, 1'b1);
      serve(15'h7FFF, 1'b1, 3, 32'h12345678);

      // full FIFO: 1 in flight, 4 queued, 6th stalled until a pop
      s0 = start_cnt;
      a0 = accept_cnt;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         req_addr = 15'(k);
         tick();
      end
      req_addr = 15'd6;
      check("full_accepts", 32'(accept_cnt - a0), 32'd5);
      check("full_ready_low", 32'(req_ready), 32'd0);
      tick();
      check("full_stall", 32'(accept_cnt - a0), 32'd5);
      check("full_ready_still", 32'(req_ready), 32'd0);
      check("full_one_start", 32'(start_cnt - s0), 32'd1);
      check("full_head_addr", 32'(cache_address), 32'd1);
      cache_data = 32'hA000_0001;
      cache_done = 1'b1;
      tick();
      cache_done = 1'b0;
      check("full_rsp1_valid", 32'(rsp_valid), 32'd1);
      check("full_rsp1_data", rsp_data, 32'hA000_0001);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("full_no_push_yet", 32'(accept_cnt - a0), 32'd5);
      serve(15'd2, 1'b0, 2, 32'hA000_0002);
      req_valid = 1'b0;
      check("full_sixth_in", 32'(accept_cnt - a0), 32'd6);
      check("full_again", 32'(req_ready), 32'd0);
      for (int k = 3; k <= 6; k++) serve(15'(k), 1'b0, 2, 32'hA000_0000 | 32'(k));
      check("full_drained", 32'(busy), 32'd0);

      // backpressure on the response
      push_one(15'h0055, 1'b0);
      wait_start();
      tick();
      cache_data = 32'hCAFEF00D;
      cache_done = 1'b1;
      tick();
      cache_done = 1'b0;
      cache_data = 32'h0;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      s0 = start_cnt;
      req_valid = 1'b1;
      req_addr  = 15'h0056;
      req_wr    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         req_valid = 1'b0;
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_data", rsp_data, 32'hCAFEF00D);
         check("bp_hold_start", 32'(cache_start), 32'd0);
      end
      check("bp_no_issue", 32'(start_cnt - s0), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_release", 32'(rsp_valid), 32'd0);
      check("bp_idle_no_start", 32'(cache_start), 32'd0);
      serve(15'h0056, 1'b0, 4, 32'h11223344);

      // timeout: no done from the cache
      cache_data = 32'hFFFF_FFFF;
      push_one(15'h0042, 1'b0);
      push_one(15'h0043, 1'b1);
      wait_start();
      check("to_addr", 32'(cache_address), 32'h42);
      n = 0;
      for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
         tick();
         n++;
      end
      check("to_latency", 32'(n), 32'd9);
      check("to_valid", 32'(rsp_valid), 32'd1);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_data", rsp_data, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("to_drop", 32'(rsp_valid), 32'd0);
      serve(15'h0043, 1'b1, 2, 32'h55AA55AA);

      // reset mid-WAIT with two requests queued
      push_one(15'h0100, 1'b1);
      push_one(15'h0101, 1'b0);
      push_one(15'h0102, 1'b0);
      tick();
      check("mr_busy_before", 32'(busy), 32'd1);
      check("mr_addr_before", 32'(cache_address), 32'h100);
      reset = 1'b1;
      #1;
      check("mr_req_ready", 32'(req_ready), 32'd1);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mr_start", 32'(cache_start), 32'd0);
      check("mr_wren", 32'(cache_wrEn), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      s0 = start_cnt;
      seen_rsp   = 1'b0;
      seen_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cache_done = (i == 3 || i == 4);
         tick();
         seen_rsp   = seen_rsp | (rsp_valid === 1'b1);
         seen_start = seen_start | (cache_start === 1'b1);
      end
      cache_done = 1'b0;
      check("mr_no_rsp", 32'(seen_rsp), 32'd0);
      check("mr_no_start", 32'(seen_start), 32'd0);
      check("mr_start_cnt", 32'(start_cnt - s0), 32'd0);
      check("mr_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_request_sequencer.md
Name: cache_request_sequencer

Overview:
- Upstream front-end for the direct-mapped cache top.
- Accepts processor-side read/write requests on a valid/ready handshake and buffers them in a small FIFO.
- Issues one request at a time to the cache (start/address/wrEn), waits for done, then returns the cache word or an error on a response handshake.
- Enforces the cache rule that address and wrEn stay stable from start until done.

Parameters:
- ADDR_W, 15, request/cache address width
- DATA_W, 32, cache output word width
- DEPTH, 4, request FIFO entries (power of two, at least 2)
- TIMEOUT, 255, maximum WAIT cycles before an error response

Ports:
- globalclock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= not full)
- req_addr  in  ADDR_W  request address
- req_wr  in  1  1 = write, 0 = read
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_W  read word (0 for writes and errors)
- rsp_wr  out  1  echo of the request type
- rsp_err  out  1  request timed out
- cache_start  out  1  start to the cache top
- cache_address  out  ADDR_W  address to the cache top
- cache_wrEn  out  1  write enable to the cache top
- cache_done  in  1  cache completion (pulse, at least one cycle)
- cache_data  in  DATA_W  cache outData word
- busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset: FIFO empty; FSM in IDLE; timeout counter 0.
  - All outputs 0 except req_ready = 1.
  - Reset is effective immediately, including mid-WAIT. The in-flight request and all queued requests are discarded, and no response is produced for them.
- Push: occurs when req_valid && req_ready at a rising edge.
  - req_ready is derived from the registered count only.
  - When the FIFO is full, no push happens even if a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if the FIFO is not empty, pop the head into the cache_address/cache_wrEn registers and go to ISSUE.
  - ISSUE: cache_start = 1 for exactly one cycle. Clear the timeout counter and go to WAIT.
  - WAIT: cache_start = 0; cache_address/cache_wrEn held.
    - On cache_done = 1: capture rsp_data (cache_data for a read, 0 for a write), set rsp_wr, set rsp_err = 0, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT (i.e. in the TIMEOUT-th WAIT cycle without done), capture rsp_data = 0 and rsp_err = 1, then go to RESP.
    - If cache_done and timeout occur in the same cycle, done wins.
  - RESP: rsp_valid = 1, with rsp_data/rsp_wr/rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid on the next cycle.
- cache_address/cache_wrEn keep their last values in IDLE. They only change on a pop.
- cache_done outside WAIT is ignored.
- Latency, with the FIFO empty and the FSM in IDLE:
  - request accepted at edge N → cache_start high in cycle N+2;
  - done sampled in cycle M → rsp_valid high in cycle M+1.
- Throughput: at most one outstanding cache request. The minimum per-request overhead is 3 cycles plus the cache's own latency.
- FIFO pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.

Decomposition:
- Shared package contains:
  - constants ADDR_W, DATA_W;
  - the FSM state enum (IDLE/ISSUE/WAIT/RESP);
  - the request struct {addr[ADDR_W], wr}.
- One sub-module, seq_req_fifo: synchronous FIFO of request structs with push/pop/full/empty/count, using the same async active-high reset.
- The FSM, timeout counter and response registers stay in cache_request_sequencer.

Test Plan:
- Single read:
  - Stimulus: push addr 0x0123, wr = 0; the cache model raises done 5 cycles after start, with cache_data = 0xDEADBEEF.
  - Required: exactly one cache_start pulse with cache_address = 0x0123; then rsp_valid with rsp_data = 0xDEADBEEF, rsp_err = 0.
- Full FIFO:
  - Stimulus: hold the cache model (no done) and push 0x0001 through 0x0006 back-to-back.
  - Required: 1 request is popped into the cache and 4 are queued. req_ready drops after the 5th accept, and the 6th is stalled until a pop.
  - Then release done each time. Required: responses arrive in order 1..5, then 6.
- Write:
  - Stimulus: push addr 0x7FFF, wr = 1; done after 3 cycles.
  - Required: cache_wrEn = 1 held stable through WAIT; rsp_wr = 1, rsp_data = 0.
- Timeout:
  - Stimulus: TIMEOUT = 8; the cache model never raises done.
  - Required: rsp_valid 8 WAIT cycles after ISSUE, with rsp_err = 1 and rsp_data = 0. The next queued request is issued after the response handshake.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 10 cycles after a read completes.
  - Required: rsp_valid/rsp_data stay stable and no new cache_start is issued. With rsp_ready = 1, the FSM returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset while in WAIT with 2 requests queued.
  - Required: outputs clear immediately (req_ready = 1, busy = 0), and no response or cache_start appears after reset is released.
